// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - dot-product sequencer feeding an external MAC datapath
//
// Purpose:
//   Accepts a job of len operand pairs, streams each accepted pair into the
//   registered MAC operand outputs, waits for the MAC pipeline to settle and
//   holds the accumulated result until it is acknowledged.
//
// Configuration:
//   MAC_DOT_CTRL_ABORT_EN - adds the abort input; abort in CLEAR/FEED/DRAIN
//                           drops the job and pulses mac_clr for one cycle.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start, len, busy    - job request, operand-pair count, job in progress
//   in_valid, in_ready,
//   in_a, in_b          - operand stream handshake and data
//   mac_a, mac_b        - registered operands to the MAC datapath
//   mac_clr             - MAC accumulator clear
//   mac_out             - MAC accumulator value (MAC_LAT cycles behind mac_a/b)
//   res_valid, res,
//   res_ack             - result handshake
//   abort               - job abort (only with MAC_DOT_CTRL_ABORT_EN)

module mac_dot_ctrl #(
  parameter int MAC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  len,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_clr,
  input  logic [37:0] mac_out,
  output logic        res_valid,
  output logic [37:0] res,
  input  logic        res_ack
`ifdef MAC_DOT_CTRL_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // DRAIN lasts MAC_LAT+1 cycles: one for the last operand register to be
  // consumed, MAC_LAT for the accumulator to reflect it.
  localparam int            DW    = $clog2(MAC_LAT + 2);
  localparam logic [DW-1:0] DLAST = DW'(MAC_LAT);

  logic [2:0]    state;
  logic [7:0]    len_q;
  logic [7:0]    cnt;
  logic [DW-1:0] dcnt;
  logic          clr_pulse;
  logic          abort_hit;
  logic          accept;

`ifdef MAC_DOT_CTRL_ABORT_EN
  assign abort_hit = abort &&
                     ((state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_FEED);
  assign res_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;

  // The accumulator is cleared while reset is held, for the CLEAR cycle of
  // every job, and for the single cycle following an abort.
  assign mac_clr   = reset || (state == S_CLEAR) || clr_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      res       <= '0;
      clr_pulse <= 1'b0;
    end else if (abort_hit) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      clr_pulse <= 1'b1;
    end else begin
      clr_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          mac_a <= '0;
          mac_b <= '0;
          if (start) begin
            if (len != 8'd0) begin
              len_q <= len;
              cnt   <= '0;
              state <= S_CLEAR;
            end else begin
              // Empty job: the result is known without touching the MAC.
              res   <= '0;
              state <= S_HOLD;
            end
          end
        end

        S_CLEAR: begin
          mac_a <= '0;
          mac_b <= '0;
          state <= S_FEED;
        end

        S_FEED: begin
          if (accept) begin
            mac_a <= in_a;
            mac_b <= in_b;
            cnt   <= cnt + 8'd1;
            if ((cnt + 8'd1) == len_q) begin
              dcnt  <= '0;
              state <= S_DRAIN;
            end
          end else begin
            // A bubble presents a zero product so the sum is unaffected.
            mac_a <= '0;
            mac_b <= '0;
          end
        end

        S_DRAIN: begin
          mac_a <= '0;
          mac_b <= '0;
          if (dcnt == DLAST) begin
            res   <= mac_out;
            state <= S_HOLD;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        S_HOLD: begin
          // A start arriving with the acknowledge only releases the result.
          if (res_ack) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          mac_a <= '0;
          mac_b <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - self-checking bench for mac_dot_ctrl with a behavioural MAC
module tb_mac_dot_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_clr;
  logic [37:0] mac_out;
  logic        res_valid;
  logic [37:0] res;
  logic        res_ack = 1'b0;
`ifdef MAC_DOT_CTRL_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int acc_cnt = 0;
  int rv_cnt = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  mac_dot_ctrl #(.MAC_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clr  (mac_clr),
    .mac_out  (mac_out),
    .res_valid(res_valid),
    .res      (res),
    .res_ack  (res_ack)
`ifdef MAC_DOT_CTRL_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  // Behavioural MAC: one-cycle accumulate, cleared by mac_clr.
  logic [37:0] acc = '0;
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else         acc <= acc + 38'(mac_a) * 38'(mac_b);
  end
  assign mac_out = acc;

  // Event counters sampled on the edge, i.e. values held during the prior cycle.
  always @(posedge clk) begin
    if (mac_clr && !reset)   clr_cnt <= clr_cnt + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (res_valid)           rv_cnt  <= rv_cnt + 1;
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [37:0] model_sum();
    logic [63:0] s = '0;
    foreach (qa[i]) s += 64'(qa[i]) * 64'(qb[i]);
    return s[37:0];
  endfunction

  task automatic fill_const(input int n, input logic [15:0] a, input logic [15:0] b);
    qa = {};
    qb = {};
    for (int i = 0; i < n; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  // Runs one complete job from the qa/qb queues and checks the result handshake.
  task automatic run_job(input string nm, input int n, input int gap, input bit noisy,
                         input logic [37:0] exp);
    int idx;
    int guard;
    int clr0;
    int acc0;
    logic [37:0] held;
    clr0 = clr_cnt;
    acc0 = acc_cnt;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    check({nm, " busy"}, busy, 1);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 5000) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_a = qa[idx];
        in_b = qb[idx];
        @(negedge clk);
        idx++;
        in_valid = 1'b0;
        if (idx == n) begin
          check({nm, " in_ready drop"}, in_ready, 0);
        end else begin
          for (int g = 0; g < gap; g++) begin
            if (noisy) start = 1'($urandom);
            @(negedge clk);
          end
        end
      end else begin
        in_valid = noisy ? 1'($urandom) : 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        if (noisy) start = 1'($urandom);
        @(negedge clk);
      end
      guard++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (idx < n) check({nm, " feed timeout"}, 64'(idx), 64'(n));
    guard = 0;
    while (!res_valid && guard < 50) begin
      in_valid = noisy ? 1'($urandom) : 1'b0;
      in_a = 16'($urandom);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check({nm, " res_valid"}, res_valid, 1);
    check({nm, " res"}, res, exp);
    check({nm, " mac_clr pulses"}, 64'(clr_cnt - clr0), (n != 0) ? 64'd1 : 64'd0);
    check({nm, " accepted"}, 64'(acc_cnt - acc0), 64'(n));
    held = res;
    repeat (2) @(negedge clk);
    check({nm, " res stable"}, {res_valid, res}, {1'b1, held});
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check({nm, " busy after ack"}, {busy, res_valid}, 2'b00);
  endtask

  typedef struct {
    int          n;
    int          gap;
    logic [15:0] a;
    logic [15:0] b;
    logic [37:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 65,  gap: 0, a: 16'hFFFF, b: 16'hFFFF, exp: 38'd4286447681};
    tbl[1] = '{n: 64,  gap: 0, a: 16'hFFFF, b: 16'hFFFF, exp: 38'd274869518400};
    tbl[2] = '{n: 1,   gap: 0, a: 16'd7,    b: 16'd9,    exp: 38'd63};
    tbl[3] = '{n: 2,   gap: 1, a: 16'd100,  b: 16'd200,  exp: 38'd40000};
    tbl[4] = '{n: 255, gap: 0, a: 16'hFFFF, b: 16'hFFFF, exp: 38'd270549516543};
    tbl[5] = '{n: 0,   gap: 0, a: 16'd5,    b: 16'd5,    exp: 38'd0};

    // Reset state.
    @(negedge clk);
    check("reset mac_clr", mac_clr, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset outputs", {busy, in_ready, res_valid, mac_clr}, 4'b0000);
    check("reset operands", {mac_a, mac_b}, 32'd0);
    check("reset res", res, 0);

    // Stray acknowledge in IDLE does nothing.
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("idle ack ignored", {busy, res_valid}, 2'b00);

    // Back-to-back and gapped versions of the reference job.
    qa = '{16'd12, 16'd102, 16'd72};
    qb = '{16'd14, 16'd14, 16'd54};
    run_job("b2b", 3, 0, 1'b0, 38'd5484);
    run_job("gapped", 3, 2, 1'b0, 38'd5484);

    // Table of constant-pair jobs, including the wrap and empty-job boundaries.
    foreach (tbl[i]) begin
      fill_const(tbl[i].n, tbl[i].a, tbl[i].b);
      run_job($sformatf("tbl%0d", i), tbl[i].n, tbl[i].gap, 1'b0, tbl[i].exp);
    end

    // Start together with acknowledge in HOLD only releases the result.
    begin
      int clr0;
      clr0 = clr_cnt;
      @(negedge clk);
      start = 1'b1;
      len = 8'd0;
      @(negedge clk);
      check("hold entered", res_valid, 1);
      len = 8'd5;
      res_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      res_ack = 1'b0;
      check("start+ack idle", busy, 0);
      @(negedge clk);
      check("start+ack no job", {busy, 8'(clr_cnt - clr0)}, 9'd0);
    end

    // Reset in the middle of FEED abandons the job.
    begin
      int rv0;
      rv0 = rv_cnt;
      @(negedge clk);
      start = 1'b1;
      len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("midjob in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_a = 16'd500;
      in_b = 16'd600;
      @(negedge clk);
      in_a = 16'd700;
      in_b = 16'd800;
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midjob reset clr", mac_clr, 1);
      check("midjob reset state", {busy, in_ready, res_valid}, 3'b000);
      reset = 1'b0;
      @(negedge clk);
      check("midjob no result", 64'(rv_cnt - rv0), 64'd0);
      qa = '{16'd7};
      qb = '{16'd9};
      run_job("after reset", 1, 0, 1'b0, 38'd63);
    end

`ifdef MAC_DOT_CTRL_ABORT_EN
    // Abort during DRAIN drops the result and clears the MAC.
    begin
      int rv0;
      rv0 = rv_cnt;
      @(negedge clk);
      start = 1'b1;
      len = 8'd1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 16'd1000;
      in_b = 16'd1000;
      @(negedge clk);
      in_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort idle", {busy, res_valid, mac_clr}, 3'b001);
      @(negedge clk);
      check("abort clr single", mac_clr, 0);
      check("abort no result", 64'(rv_cnt - rv0), 64'd0);
      qa = '{16'd12};
      qb = '{16'd14};
      run_job("after abort", 1, 0, 1'b0, 38'd168);
    end
`endif

    // Randomised jobs with bubbles, ignored starts and stray in_valid outside FEED.
    for (int j = 0; j < 10; j++) begin
      int n;
      n = int'($urandom_range(1, 24));
      qa = {};
      qb = {};
      for (int i = 0; i < n; i++) begin
        qa.push_back(16'($urandom));
        qb.push_back(16'($urandom));
      end
      run_job($sformatf("rand%0d", j), n, int'($urandom_range(0, 2)), 1'b1, model_sum());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 SHALL have parameter MAC_LAT, default 1: cycles from mac_a/mac_b register update to mac_out reflecting that product.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a dot-product job; sampled only in IDLE.
REQ-005 SHALL have port len, input, 8: number of operand pairs, latched on accepted start.
REQ-006 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 16) and in_b (input, 16): operand stream handshake.
REQ-008 SHALL have ports mac_a (output, 16) and mac_b (output, 16): registered operands to the MAC datapath.
REQ-009 SHALL have port mac_clr, output, 1: MAC accumulator clear, driving the MAC reset.
REQ-010 SHALL have port mac_out, input, 38: MAC accumulator value.
REQ-011 SHALL have ports res_valid (output, 1), res (output, 38) and res_ack (input, 1): result handshake.

Function
REQ-012 SHALL implement the FSM states IDLE, CLEAR, FEED, DRAIN and HOLD.
REQ-013 In IDLE with start=1 and len!=0, SHALL latch len, clear the pair counter and go to CLEAR.
REQ-014 In IDLE with start=1 and len=0, SHALL set res=0 and go directly to HOLD without pulsing mac_clr.
REQ-015 CLEAR SHALL last exactly one cycle with mac_clr=1 and mac_a=mac_b=0, then go to FEED.
REQ-016 In FEED, in_ready SHALL be 1; a pair is accepted on a cycle with in_valid&in_ready, registering mac_a<=in_a, mac_b<=in_b and incrementing the counter.
REQ-017 In FEED, a cycle without acceptance SHALL register mac_a=mac_b=0 so that a bubble adds zero.
REQ-018 When the accepted count equals len, SHALL go to DRAIN; in_ready SHALL be 0 from the following cycle.
REQ-019 DRAIN SHALL hold mac_a=mac_b=0 for MAC_LAT+1 cycles, then capture res<=mac_out and go to HOLD.
REQ-020 In HOLD, res_valid SHALL be 1 and res SHALL be stable until a cycle with res_ack=1, after which the FSM returns to IDLE.
REQ-021 res_ack in IDLE, start in any non-IDLE state, and in_valid outside FEED SHALL be ignored.
REQ-022 Arithmetic SHALL be unsigned; res SHALL equal the sum of the len products modulo 2^38, with no saturation or overflow flag.
REQ-023 start with res_ack=1 in the same cycle while in HOLD SHALL return to IDLE only; the start is not accepted.
REQ-024 mac_clr SHALL be 0 in every state other than CLEAR and reset.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge and clear the counter, busy, in_ready, res_valid, res, mac_a and mac_b to 0.
REQ-026 mac_clr SHALL be 1 during reset; reset mid-job SHALL abandon the job with no res_valid pulse.

Configuration
REQ-027 With MAC_DOT_CTRL_ABORT_EN defined, SHALL add a 1-bit input abort.
REQ-028 With MAC_DOT_CTRL_ABORT_EN defined, abort=1 in CLEAR, FEED or DRAIN SHALL go to IDLE next cycle with mac_clr pulsed for one cycle and no res_valid.
REQ-029 With MAC_DOT_CTRL_ABORT_EN defined, abort SHALL be ignored in IDLE and HOLD.
REQ-030 Without MAC_DOT_CTRL_ABORT_EN defined, the abort port SHALL NOT exist and behaviour SHALL be as REQ-012 to REQ-024.

Verification
REQ-031 len=3, pairs (12,14),(102,14),(72,54) streamed back-to-back -> res_valid with res=5484; busy low one cycle after res_ack.
REQ-032 Same job with in_valid low for 2 cycles between each pair -> res=5484, and in_ready drops after the 3rd acceptance.
REQ-033 len=0 start -> HOLD with res=0, no mac_clr pulse, no in_ready.
REQ-034 len=65, all pairs (65535,65535) -> res=4286447681 (wrap modulo 2^38); len=64 with the same pairs -> res=274869518400.
REQ-035 reset asserted mid-FEED after 2 of 3 pairs, then a new len=1 job with (7,9) -> res=63, with no stale accumulation.
REQ-036 With MAC_DOT_CTRL_ABORT_EN defined: abort during DRAIN -> IDLE, mac_clr pulse, no res_valid; a subsequent len=1 job with (12,14) -> res=168.
